// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM state encoding, status-byte layout and frame-length decode
// for the SPI command controller.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_READ       = 8'h01;
    localparam logic [7:0] OP_WRITE      = 8'h02;
    localparam logic [7:0] OP_READ_NEXT  = 8'h03;
    localparam logic [7:0] OP_WRITE_NEXT = 8'h04;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STAT_BUSY_BIT = 7;
    localparam int STAT_ERR_BIT  = 6;

    // Unknown opcodes still report one byte so the buffer never waits forever.
    function automatic logic [2:0] frame_len(input logic [7:0] op);
        case (op)
            OP_READ:       return 3'd3;
            OP_WRITE:      return 3'd4;
            OP_WRITE_NEXT: return 3'd2;
            default:       return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_sync2.sv
// Single-bit multi-flop synchronizer with a selectable reset level.
module sync2 #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Sequences the SPI byte buffer: decodes each completed frame into one bus
// read or write and presents read data and status for the following frame.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs_n,
    input  logic                  spi_valid,
    input  logic [3:0][7:0]       spi_rx,
    output logic [2:0]            spi_length,
    output logic [3:0][7:0]       spi_tx,
    output logic                  spi_buf_reset,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    output logic                  bus_we,
    output logic                  bus_req,
    input  logic [7:0]            bus_rdata,
    input  logic                  bus_ack,
    output logic                  busy
);

    logic                  w_valid_sync;
    logic                  w_cs_sync;
    logic                  w_valid_rise;
    logic [15:0]           w_next16;
    logic [7:0]            w_status;

    state_t                r_state;
    logic                  r_valid_d;
    logic                  r_buf_reset;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [7:0]            r_bus_wdata;
    logic                  r_bus_we;
    logic                  r_bus_req;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [7:0]            r_rd_data;
    logic                  r_err;
    logic [2:0]            r_last_op;

    sync2 #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_valid (
        .clk   (clk),
        .reset (reset),
        .i_d   (spi_valid),
        .o_q   (w_valid_sync)
    );

    // cs_n idles high, so its synchronizer resets to the deselected level.
    sync2 #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .i_d   (spi_cs_n),
        .o_q   (w_cs_sync)
    );

    assign w_valid_rise = w_valid_sync & ~r_valid_d;
    assign spi_length   = frame_len(spi_rx[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_d   <= 1'b0;
            r_buf_reset <= 1'b1;
        end else begin
            r_valid_d   <= w_valid_sync;
            r_buf_reset <= w_cs_sync | (r_state != IDLE);
        end
    end

    // A frame is decoded in the same cycle valid_rise is seen; bus outputs
    // are loaded directly so they are stable for the whole REQ state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bus_addr  <= '0;
            r_bus_wdata <= 8'h00;
            r_bus_we    <= 1'b0;
            r_bus_req   <= 1'b0;
            r_next_addr <= '0;
            r_rd_data   <= 8'h00;
            r_err       <= 1'b0;
            r_last_op   <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid_rise) begin
                        r_last_op <= spi_rx[0][2:0];
                        case (spi_rx[0])
                            OP_NOP: begin
                                r_err   <= 1'b0;
                                r_state <= DONE;
                            end
                            OP_READ: begin
                                r_bus_addr <= ADDR_WIDTH'({spi_rx[1], spi_rx[2]});
                                r_bus_we   <= 1'b0;
                                r_bus_req  <= 1'b1;
                                r_state    <= REQ;
                            end
                            OP_WRITE: begin
                                r_bus_addr  <= ADDR_WIDTH'({spi_rx[1], spi_rx[2]});
                                r_bus_wdata <= spi_rx[3];
                                r_bus_we    <= 1'b1;
                                r_bus_req   <= 1'b1;
                                r_state     <= REQ;
                            end
                            OP_READ_NEXT: begin
                                r_bus_addr <= r_next_addr;
                                r_bus_we   <= 1'b0;
                                r_bus_req  <= 1'b1;
                                r_state    <= REQ;
                            end
                            OP_WRITE_NEXT: begin
                                r_bus_addr  <= r_next_addr;
                                r_bus_wdata <= spi_rx[1];
                                r_bus_we    <= 1'b1;
                                r_bus_req   <= 1'b1;
                                r_state     <= REQ;
                            end
                            default: begin
                                r_err   <= 1'b1;
                                r_state <= DONE;
                            end
                        endcase
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        r_bus_req   <= 1'b0;
                        r_next_addr <= r_bus_addr + ADDR_WIDTH'(1);
                        if (!r_bus_we) begin
                            r_rd_data <= bus_rdata;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (w_cs_sync) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_next16 = 16'(r_next_addr);

    always_comb begin
        w_status                = 8'h00;
        w_status[STAT_BUSY_BIT] = r_bus_req;
        w_status[STAT_ERR_BIT]  = r_err;
        w_status[2:0]           = r_last_op;
    end

    assign spi_tx[0]     = r_rd_data;
    assign spi_tx[1]     = w_status;
    assign spi_tx[2]     = w_next16[15:8];
    assign spi_tx[3]     = w_next16[7:0];

    assign spi_buf_reset = r_buf_reset;
    assign bus_addr      = r_bus_addr;
    assign bus_wdata     = r_bus_wdata;
    assign bus_we        = r_bus_we;
    assign bus_req       = r_bus_req;
    assign busy          = r_bus_req;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl: frames are driven straight
// onto the buffer-side ports and the bus is answered by hand.
module tb_spi_cmd_ctrl;

    logic            clk = 1'b0;
    logic            reset;
    logic            spi_cs_n;
    logic            spi_valid;
    logic [3:0][7:0] spi_rx;
    logic [2:0]      spi_length;
    logic [3:0][7:0] spi_tx;
    logic            spi_buf_reset;
    logic [15:0]     bus_addr;
    logic [7:0]      bus_wdata;
    logic            bus_we;
    logic            bus_req;
    logic [7:0]      bus_rdata;
    logic            bus_ack;
    logic            busy;

    int   vectors     = 0;
    int   miscompares = 0;
    logic sawReq      = 1'b0;

    spi_cmd_ctrl #(
        .ADDR_WIDTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_cs_n      (spi_cs_n),
        .spi_valid     (spi_valid),
        .spi_rx        (spi_rx),
        .spi_length    (spi_length),
        .spi_tx        (spi_tx),
        .spi_buf_reset (spi_buf_reset),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_req       (bus_req),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Advance on falling edges so outputs are sampled away from the active edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus_req) sawReq = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3);
        spi_rx   = {b3, b2, b1, b0};
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic endFrame();
        spi_cs_n  = 1'b1;
        spi_valid = 1'b0;
        tick(5);
    endtask

    task automatic waitReq(input string tag);
        for (int i = 0; i < 20 && !bus_req; i++) tick(1);
        checkOutput(tag, {31'd0, bus_req}, 32'd1);
    endtask

    task automatic ackBus(input logic [7:0] rdata);
        bus_rdata = rdata;
        bus_ack   = 1'b1;
        tick(1);
        bus_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        spi_cs_n  = 1'b1;
        spi_valid = 1'b0;
        spi_rx    = '0;
        bus_rdata = 8'h00;
        bus_ack   = 1'b0;
        tick(2);
        checkOutput("rst_buf_reset", {31'd0, spi_buf_reset}, 32'd1);
        checkOutput("rst_bus_req",   {31'd0, bus_req}, 32'd0);
        checkOutput("rst_busy",      {31'd0, busy}, 32'd0);
        checkOutput("rst_spi_tx",    spi_tx, 32'h0000_0000);
        checkOutput("rst_bus_addr",  {16'd0, bus_addr}, 32'd0);
        reset = 1'b0;
        tick(4);
        checkOutput("idle_cs_high_buf_reset", {31'd0, spi_buf_reset}, 32'd1);

        // WRITE 02 12 34 A5
        applyStimulus(8'h02, 8'h12, 8'h34, 8'hA5);
        checkOutput("wr_buf_reset_low", {31'd0, spi_buf_reset}, 32'd0);
        checkOutput("wr_length", {29'd0, spi_length}, 32'd4);
        spi_valid = 1'b1;
        waitReq("wr_req");
        checkOutput("wr_addr",  {16'd0, bus_addr}, 32'h1234);
        checkOutput("wr_we",    {31'd0, bus_we}, 32'd1);
        checkOutput("wr_wdata", {24'd0, bus_wdata}, 32'hA5);
        checkOutput("wr_busy",  {31'd0, busy}, 32'd1);
        tick(3);
        checkOutput("wr_req_held", {31'd0, bus_req}, 32'd1);
        ackBus(8'h00);
        checkOutput("wr_req_drop", {31'd0, bus_req}, 32'd0);
        checkOutput("wr_busy_drop", {31'd0, busy}, 32'd0);
        checkOutput("wr_status", {24'd0, spi_tx[1]}, 32'h02);
        checkOutput("wr_next_addr", {16'd0, spi_tx[2], spi_tx[3]}, 32'h1235);
        sawReq    = 1'b0;
        spi_valid = 1'b0;
        tick(3);
        spi_valid = 1'b1;
        tick(6);
        checkOutput("wr_second_valid_ignored", {31'd0, sawReq}, 32'd0);
        endFrame();
        checkOutput("wr_end_buf_reset", {31'd0, spi_buf_reset}, 32'd1);

        // READ 01 80 00 returning 0x5C
        applyStimulus(8'h01, 8'h80, 8'h00, 8'h00);
        checkOutput("rd_length", {29'd0, spi_length}, 32'd3);
        spi_valid = 1'b1;
        waitReq("rd_req");
        checkOutput("rd_addr", {16'd0, bus_addr}, 32'h8000);
        checkOutput("rd_we",   {31'd0, bus_we}, 32'd0);
        ackBus(8'h5C);
        endFrame();
        checkOutput("rd_tx0",  {24'd0, spi_tx[0]}, 32'h5C);
        checkOutput("rd_tx1",  {24'd0, spi_tx[1]}, 32'h01);
        checkOutput("rd_tx23", {16'd0, spi_tx[2], spi_tx[3]}, 32'h8001);

        // READ at 0xFFFF then READ_NEXT wraps to 0x0000
        applyStimulus(8'h01, 8'hFF, 8'hFF, 8'h00);
        spi_valid = 1'b1;
        waitReq("rdmax_req");
        checkOutput("rdmax_addr", {16'd0, bus_addr}, 32'hFFFF);
        ackBus(8'h11);
        endFrame();
        checkOutput("rdmax_wrap", {16'd0, spi_tx[2], spi_tx[3]}, 32'h0000);
        applyStimulus(8'h03, 8'h00, 8'h00, 8'h00);
        checkOutput("rdnext_length", {29'd0, spi_length}, 32'd1);
        spi_valid = 1'b1;
        waitReq("rdnext_req");
        checkOutput("rdnext_addr", {16'd0, bus_addr}, 32'h0000);
        checkOutput("rdnext_we",   {31'd0, bus_we}, 32'd0);
        ackBus(8'h22);
        endFrame();
        checkOutput("rdnext_tx0",  {24'd0, spi_tx[0]}, 32'h22);
        checkOutput("rdnext_next", {16'd0, spi_tx[2], spi_tx[3]}, 32'h0001);

        // Unknown opcode 7F sets err; NOP clears it
        applyStimulus(8'h7F, 8'h00, 8'h00, 8'h00);
        checkOutput("unk_length", {29'd0, spi_length}, 32'd1);
        sawReq    = 1'b0;
        spi_valid = 1'b1;
        tick(8);
        checkOutput("unk_no_req", {31'd0, sawReq}, 32'd0);
        checkOutput("unk_status", {24'd0, spi_tx[1]}, 32'h47);
        endFrame();
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("nop_length", {29'd0, spi_length}, 32'd1);
        spi_valid = 1'b1;
        tick(8);
        checkOutput("nop_status", {24'd0, spi_tx[1]}, 32'h00);
        endFrame();

        // Short frame: cs_n rises after two WRITE bytes, no valid
        sawReq = 1'b0;
        applyStimulus(8'h02, 8'h12, 8'h00, 8'h00);
        checkOutput("short_buf_reset_low", {31'd0, spi_buf_reset}, 32'd0);
        spi_cs_n = 1'b1;
        tick(3);
        checkOutput("short_buf_reset", {31'd0, spi_buf_reset}, 32'd1);
        tick(5);
        checkOutput("short_no_req", {31'd0, sawReq}, 32'd0);

        // Stray bus_ack in IDLE changes nothing
        bus_rdata = 8'hEE;
        bus_ack   = 1'b1;
        tick(1);
        bus_ack   = 1'b0;
        tick(1);
        checkOutput("stray_ack_tx0",  {24'd0, spi_tx[0]}, 32'h22);
        checkOutput("stray_ack_next", {16'd0, spi_tx[2], spi_tx[3]}, 32'h0001);

        // Reset while bus_req is held, then a normal WRITE_NEXT frame
        applyStimulus(8'h02, 8'h00, 8'h10, 8'h77);
        spi_valid = 1'b1;
        waitReq("rstreq_req");
        checkOutput("rstreq_addr", {16'd0, bus_addr}, 32'h0010);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstreq_req_async", {31'd0, bus_req}, 32'd0);
        checkOutput("rstreq_busy",      {31'd0, busy}, 32'd0);
        checkOutput("rstreq_buf_reset", {31'd0, spi_buf_reset}, 32'd1);
        checkOutput("rstreq_tx",        spi_tx, 32'h0000_0000);
        checkOutput("rstreq_wdata",     {24'd0, bus_wdata}, 32'h00);
        @(negedge clk);
        reset     = 1'b0;
        spi_cs_n  = 1'b1;
        spi_valid = 1'b0;
        tick(5);
        applyStimulus(8'h04, 8'h99, 8'h00, 8'h00);
        checkOutput("wrnext_length", {29'd0, spi_length}, 32'd2);
        spi_valid = 1'b1;
        waitReq("wrnext_req");
        checkOutput("wrnext_addr",  {16'd0, bus_addr}, 32'h0000);
        checkOutput("wrnext_we",    {31'd0, bus_we}, 32'd1);
        checkOutput("wrnext_wdata", {24'd0, bus_wdata}, 32'h99);
        ackBus(8'h00);
        checkOutput("wrnext_status", {24'd0, spi_tx[1]}, 32'h04);
        checkOutput("wrnext_next",   {16'd0, spi_tx[2], spi_tx[3]}, 32'h0001);
        endFrame();

        // cs_n rises during REQ: the bus cycle still completes
        applyStimulus(8'h01, 8'h00, 8'h40, 8'h00);
        spi_valid = 1'b1;
        waitReq("csreq_req");
        spi_cs_n  = 1'b1;
        spi_valid = 1'b0;
        tick(6);
        checkOutput("csreq_req_held", {31'd0, bus_req}, 32'd1);
        ackBus(8'h3C);
        tick(3);
        checkOutput("csreq_buf_reset", {31'd0, spi_buf_reset}, 32'd1);
        checkOutput("csreq_tx0",       {24'd0, spi_tx[0]}, 32'h3C);
        checkOutput("csreq_next",      {16'd0, spi_tx[2], spi_tx[3]}, 32'h0041);
        spi_cs_n = 1'b0;
        tick(4);
        checkOutput("csreq_back_idle", {31'd0, spi_buf_reset}, 32'd0);
        endFrame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
System-clock controller that sequences the SPI receive/transmit byte buffer. It supplies the buffer's expected frame length from the command byte and resets the buffer between frames. It crosses the frame-complete event into the clk domain, decodes the frame into a single PET bus read or write, and returns read data and status on the buffer's tx bytes for the next frame.

Parameters:
ADDR_WIDTH, 16, bus address width; addresses wrap modulo 2^ADDR_WIDTH.
SYNC_STAGES, 2, flip-flop depth of the spi_valid and spi_cs_n synchronizers (≥2).

Ports:
clk  in  1  system clock; ≥8× spi_sclk frequency
reset  in  1  asynchronous, active-high
spi_cs_n  in  1  raw SPI chip select (async to clk)
spi_valid  in  1  buffer frame-complete flag (async to clk)
spi_rx  in  8×4  buffer rx bytes; stable while spi_valid=1
spi_length  out  3  expected frame length in bytes to buffer
spi_tx  out  8×4  bytes the buffer shifts out
spi_buf_reset  out  1  buffer reset
bus_addr  out  ADDR_WIDTH  bus address
bus_wdata  out  8  write data
bus_we  out  1  1=write, 0=read; valid with bus_req
bus_req  out  1  bus request; held until bus_ack
bus_rdata  in  8  read data; sampled on bus_ack
bus_ack  in  1  one-cycle completion strobe
busy  out  1  1 while a bus cycle is requested or pending

Behaviour:
- Clocking: one clock clk; reset asynchronous, active-high, named reset.
- Reset values: spi_buf_reset=1, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0, spi_tx all 0, state=IDLE, next_addr=0, err=0.
- spi_length is a combinational decode of spi_rx[0]:
  - 0x00 NOP → 1.
  - 0x01 READ {cmd, addr_hi, addr_lo} → 3.
  - 0x02 WRITE {cmd, addr_hi, addr_lo, data} → 4.
  - 0x03 READ_NEXT → 1.
  - 0x04 WRITE_NEXT {cmd, data} → 2.
  - Any other value → 1.
  - Minimum is 1, so a stale rx[0] at count 0 never produces a false valid.
- spi_valid and spi_cs_n each pass through a SYNC_STAGES synchronizer. valid_rise is a single-cycle pulse on the 0→1 edge of the synchronized valid.
- spi_buf_reset is registered: 1 while synchronized cs_n=1 or state≠IDLE, else 0.
- FSM:
  - IDLE: on valid_rise, latch spi_rx[0..3] into local registers in the same cycle.
    - Bus commands go to REQ.
    - NOP goes to DONE.
    - Unknown opcode sets err=1 and goes to DONE.
  - REQ: bus_req=1, busy=1. Address source:
    - READ/WRITE: addr = {rx1, rx2}.
    - *_NEXT: addr = next_addr.
    - bus_wdata = rx3 (WRITE) or rx1 (WRITE_NEXT).
    - Outputs stay stable until bus_ack. On bus_ack: bus_req=0 next cycle, next_addr ← addr+1 (wraps), go to DONE.
    - Reads also capture bus_rdata into rd_data on bus_ack.
  - DONE: busy=0. Wait for synchronized cs_n=1, then go to IDLE.
- Transmit bytes:
  - spi_tx[0] = rd_data.
  - spi_tx[1] = {busy, err, 3'b0, last_opcode[2:0]}.
  - spi_tx[2] = next_addr[15:8], spi_tx[3] = next_addr[7:0].
- err is sticky; cleared by reset or by a successful NOP.
- Boundary conditions:
  - cs_n deasserts before valid (short frame): no bus cycle, buffer reset, stay in IDLE.
  - cs_n deasserts during REQ: the bus cycle completes (committed). FSM then passes through DONE straight to IDLE.
  - Extra bytes beyond length are ignored; only the first valid_rise per frame is acted on.
  - valid_rise coincident with reset: reset wins.
  - bus_ack while not in REQ: ignored.
  - next_addr 0xFFFF+1 → 0x0000.
  - Reset mid-REQ: bus_req drops asynchronously.

Decomposition:
- Package spi_cmd_pkg holds:
  - opcode localparams (OP_NOP=0x00 … OP_WRITE_NEXT=0x04);
  - a frame-length function;
  - the state enum {IDLE, REQ, DONE};
  - status-byte bit positions.
- Sub-module: sync2 (parameterized-depth single-bit synchronizer), instantiated twice.

Test Plan:
- WRITE frame 02 12 34 A5 → one bus_req with addr=0x1234, we=1, wdata=0xA5; after ack, next_addr=0x1235, busy returns to 0.
- READ frame 01 80 00, bus_rdata=0x5C on ack → addr=0x8000, we=0; next frame's first tx byte = 0x5C and spi_tx[2:3] = 0x80,0x01.
- READ at 0xFFFF, then READ_NEXT 03 → second request addr=0x0000 (wrap), next_addr=0x0001.
- Unknown opcode 7F → spi_length=1, no bus_req, status byte bit6=1; a following NOP 00 clears bit6.
- cs_n raised after 2 bytes of a WRITE frame → no bus_req; spi_buf_reset=1 within SYNC_STAGES+1 clks.
- reset asserted while bus_req=1 and bus_ack withheld → bus_req=0 immediately; all outputs at reset values; next frame runs normally.
